// File: rtl/nic_link_allocator.sv
// Round-robin link allocator: picks one fifo_out_buffer per cycle for the NIC output link.
// Define LA_PACKET_LOCK_EN to keep the link with a head-flit winner until its tail is granted.

module nic_la_lane #(
  parameter int IDX = 0,
  parameter int W   = 3
) (
  input  logic         req_i,
  input  logic [W-1:0] ptr_i,
  output logic         hi_o
);
  // Request sits at or above the round-robin pointer: it belongs to the first scan segment.
  assign hi_o = req_i && (W'(IDX) >= ptr_i);
endmodule

module nic_link_allocator #(
  parameter int N_FIFO_OUT_BUFFER      = 6,
  parameter int N_BITS_FIFO_OUT_BUFFER = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_FIFO_OUT_BUFFER-1:0]      r_la_i,
  input  logic [N_FIFO_OUT_BUFFER-1:0]      tail_i,
  input  logic                              link_ready_i,
  output logic                              g_la_o,
  output logic [N_BITS_FIFO_OUT_BUFFER-1:0] g_la_fifo_out_buffer_id_o,
  output logic                              locked_o,
  output logic [N_BITS_FIFO_OUT_BUFFER-1:0] owner_o
);
  localparam int N = N_FIFO_OUT_BUFFER;
  localparam int W = N_BITS_FIFO_OUT_BUFFER;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0] req_hi;
  logic [W-1:0] win_hi, win_any, winner, next_ptr;
  logic         hit_hi;
  logic         gnt;
  logic [W-1:0] gnt_id;
  logic         locked;
  logic [W-1:0] owner;

  for (genvar i = 0; i < N; i++) begin : g_lane
    nic_la_lane #(.IDX(i), .W(W)) u_lane (
      .req_i (r_la_i[i]),
      .ptr_i (rr_ptr_q),
      .hi_o  (req_hi[i])
    );
  end

  // Lowest set bit at/above the pointer wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    win_hi  = '0;
    win_any = '0;
    hit_hi  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_hi[i]) begin
        win_hi = W'(i);
        hit_hi = 1'b1;
      end
      if (r_la_i[i]) win_any = W'(i);
    end
    winner   = hit_hi ? win_hi : win_any;
    next_ptr = (winner == LAST) ? '0 : winner + 1'b1;
  end

`ifdef LA_PACKET_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_e;
  state_e       state_q, state_d;
  logic [W-1:0] owner_q, owner_d;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt      = 1'b0;
    gnt_id   = '0;
    case (state_q)
      ARB: begin
        if (link_ready_i && |r_la_i) begin
          gnt      = 1'b1;
          gnt_id   = winner;
          rr_ptr_d = next_ptr;
          if (!tail_i[winner]) begin
            state_d = LOCKED;
            owner_d = winner;
          end
        end
      end
      LOCKED: begin
        // Pointer already moved past the owner at the head flit; only the owner may send.
        if (link_ready_i && r_la_i[owner_q]) begin
          gnt    = 1'b1;
          gnt_id = owner_q;
          if (tail_i[owner_q]) begin
            state_d = ARB;
            owner_d = '0;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign locked = (state_q == LOCKED);
  assign owner  = owner_q;
`else
  logic unused_tail;
  assign unused_tail = ^tail_i;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    gnt      = 1'b0;
    gnt_id   = '0;
    if (link_ready_i && |r_la_i) begin
      gnt      = 1'b1;
      gnt_id   = winner;
      rr_ptr_d = next_ptr;
    end
  end

  assign locked = 1'b0;
  assign owner  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  // Outputs are forced quiet for the whole reset cycle, not just after the edge.
  assign g_la_o                    = gnt && !rst;
  assign g_la_fifo_out_buffer_id_o = (gnt && !rst) ? gnt_id : '0;
  assign locked_o                  = locked && !rst;
  assign owner_o                   = (locked && !rst) ? owner : '0;
endmodule

// File: tb/tb_nic_link_allocator.sv
// Directed-vector bench for nic_link_allocator; lock checks enabled with LA_PACKET_LOCK_EN.

module tb_nic_link_allocator;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] r_la_i, tail_i;
  logic       link_ready_i;
  logic       g_la_o;
  logic [2:0] g_la_fifo_out_buffer_id_o;
  logic       locked_o;
  logic [2:0] owner_o;

  int checks = 0;
  int errors = 0;

  nic_link_allocator #(.N_FIFO_OUT_BUFFER(6), .N_BITS_FIFO_OUT_BUFFER(3)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .r_la_i                    (r_la_i),
    .tail_i                    (tail_i),
    .link_ready_i              (link_ready_i),
    .g_la_o                    (g_la_o),
    .g_la_fifo_out_buffer_id_o (g_la_fifo_out_buffer_id_o),
    .locked_o                  (locked_o),
    .owner_o                   (owner_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Sample mid-cycle with current inputs, then advance past the next rising edge.
  task automatic step(input string tag, input logic g, input logic [2:0] id,
                      input logic lk, input logic [2:0] own);
    @(negedge clk);
    chk({tag, ".g"},   32'(g_la_o), 32'(g));
    chk({tag, ".id"},  32'(g_la_fifo_out_buffer_id_o), 32'(id));
    chk({tag, ".lk"},  32'(locked_o), 32'(lk));
    chk({tag, ".own"}, 32'(owner_o), 32'(own));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; r_la_i = '0; tail_i = '1; link_ready_i = 1'b0;
    @(posedge clk); #1;
    // Outputs quiet during reset even with every request up.
    r_la_i = 6'b111111; link_ready_i = 1'b1;
    step("rst_hold", 0, 0, 0, 0);
    rst = 1'b0; r_la_i = '0;

    for (int i = 0; i < 3; i++) step("idle", 0, 0, 0, 0);

    r_la_i = 6'b100101; tail_i = '1;
    step("rr0", 1, 0, 0, 0);
    step("rr1", 1, 2, 0, 0);
    step("rr2", 1, 5, 0, 0);
    step("rr3", 1, 0, 0, 0);
    step("rr4", 1, 2, 0, 0);  // ptr now 3

    r_la_i = 6'b000010; link_ready_i = 1'b0;
    step("nrdy0", 0, 0, 0, 0);
    step("nrdy1", 0, 0, 0, 0);
    link_ready_i = 1'b1;
    step("rdy", 1, 1, 0, 0);  // ptr now 2

    r_la_i = 6'b010000;
    step("pre_wrap", 1, 4, 0, 0);  // ptr now 5
    r_la_i = 6'b100001;
    step("wrap5", 1, 5, 0, 0);
    step("wrap0", 1, 0, 0, 0);  // ptr now 1

    r_la_i = 6'b001000;
    for (int i = 0; i < 3; i++) step("single", 1, 3, 0, 0);  // ptr now 4

    r_la_i = 6'b000100;
    step("pre_lock", 1, 2, 0, 0);  // ptr now 3

    r_la_i = 6'b001010; tail_i = '0;
`ifdef LA_PACKET_LOCK_EN
    step("lk_head", 1, 3, 0, 0);
    step("lk_body", 1, 3, 1, 3);
    r_la_i = 6'b000010;
    step("lk_bubble", 0, 0, 1, 3);
    r_la_i = 6'b001010;
    step("lk_body2", 1, 3, 1, 3);
    tail_i = 6'b001000;
    step("lk_tail", 1, 3, 1, 3);
    tail_i = '0;
    r_la_i = 6'b000010; tail_i = 6'b000010;
    step("lk_after", 1, 1, 0, 0);  // ptr now 2

    r_la_i = 6'b010000; tail_i = '0;
    step("lk4_head", 1, 4, 0, 0);
    r_la_i = 6'b010001;
    step("lk4_body", 1, 4, 1, 4);
`else
    // Without locking, a non-tail flit does not hold the link.
    step("nolk_a", 1, 3, 0, 0);
    step("nolk_b", 1, 1, 0, 0);
    step("nolk_c", 1, 3, 0, 0);
    r_la_i = 6'b010001;
`endif
    rst = 1'b1;
    step("rst_mid", 0, 0, 0, 0);
    rst = 1'b0; tail_i = '1;
    step("post_rst", 1, 0, 0, 0);
    step("post_rst2", 1, 4, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nic_link_allocator.md
# nic_link_allocator

Link-allocation (LA) arbiter for the NIC output path. It picks which fifo_out_buffer drives the single NIC-to-NoC output link in the current cycle, one flit per cycle. Arbitration is round-robin so no buffer starves. With packet locking compiled in, the winner of a head flit keeps the link until its tail flit has been granted. The block drives the `g_la_i` / `g_la_fifo_out_buffer_id_i` pair of wb_slave_interface from its `r_la_o` vector.

## Interface
Parameters:
- `N_FIFO_OUT_BUFFER`, 6, number of requesters (any value ≥2, need not be a power of two)
- `N_BITS_FIFO_OUT_BUFFER`, 3, width of the winner id; must satisfy 2^N_BITS ≥ N_FIFO_OUT_BUFFER

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `r_la_i`  in  N_FIFO_OUT_BUFFER  bit i high: fifo_out_buffer i has a flit ready
- `tail_i`  in  N_FIFO_OUT_BUFFER  bit i high: the flit buffer i would send now is a tail (or single-flit packet); only sampled for the granted requester
- `link_ready_i`  in  1  downstream can accept a flit this cycle
- `g_la_o`  out  1  a grant is issued this cycle
- `g_la_fifo_out_buffer_id_o`  out  N_BITS_FIFO_OUT_BUFFER  unsigned id of the winner; 0 when `g_la_o` is low
- `locked_o`  out  1  link reserved for `owner_o` (always 0 without the macro)
- `owner_o`  out  N_BITS_FIFO_OUT_BUFFER  current lock owner; 0 when not locked

## Operation
- State: `rr_ptr` (N_BITS wide, range 0..N-1), FSM {ARB, LOCKED}, `owner` register.
- ARB:
  - if `link_ready_i` and `r_la_i`≠0: winner = first set bit scanning `rr_ptr`, `rr_ptr`+1, …, N-1, 0, …, `rr_ptr`-1.
  - `g_la_o`=1, id=winner.
  - On the clock edge: `rr_ptr` ← winner+1, wrapping N-1 → 0.
  - Lock (macro only): if `tail_i[winner]`=0 → LOCKED, `owner` ← winner; otherwise stay in ARB.
  - No request or `link_ready_i`=0: no grant, no state change.
- LOCKED:
  - Grant only when `r_la_i[owner]` and `link_ready_i` are both high; requests from other buffers are ignored.
  - Owner request low (bubble inside the packet): no grant, stay LOCKED.
  - Granted flit with `tail_i[owner]`=1 → ARB on the edge.
  - `rr_ptr` is not updated while LOCKED; it was already advanced past the owner when the head flit was granted.
- At most one grant per cycle; `g_la_o` never high while `link_ready_i` is low.
- `tail_i` bits of non-granted requesters are don't-care.

## Timing
- Grant is combinational from `r_la_i`, `tail_i`, `link_ready_i` and registered state: zero-cycle request-to-grant latency.
- The granted buffer presents its flit on the following cycle, as the wb_slave_interface output stage expects.
- Registered state changes only at the rising edge of `clk`.
- Reset, taking effect at the edge where `rst`=1:
  - FSM=ARB, `rr_ptr`=0, `owner`=0.
  - While `rst` is high, `g_la_o`=0, id=0, `locked_o`=0, `owner_o`=0, regardless of other inputs.
- Reset while LOCKED drops the lock immediately; the partially sent packet is abandoned.
- Wrap-around: winner N-1 sets `rr_ptr`=0. Ids ≥N are never produced.
- Single requester: it is granted every cycle `link_ready_i` is high.
- Head and tail in the same flit (single-flit packet): grant, no lock.

## Configuration
- `LA_PACKET_LOCK_EN` defined:
  - wormhole behaviour as above; flits of different packets never interleave on the link.
- Not defined:
  - the FSM is permanently ARB and `tail_i` is ignored;
  - round-robin arbitration is re-run every cycle (flit-level interleaving);
  - `locked_o`=0 and `owner_o`=0 constant.

## Test plan
- Reset, then `r_la_i`=6'b000000, `link_ready_i`=1 for 3 cycles → `g_la_o`=0, id=0, `locked_o`=0.
- No lock, `r_la_i`=6'b100101 held, `tail_i`=all 1 → grant ids 0,2,5,0,2 on consecutive cycles.
- `link_ready_i`=0 for 2 cycles with `r_la_i`=6'b000010 → no grant, `rr_ptr` unchanged; `link_ready_i`=1 → id 1.
- Wrap: `rr_ptr`=5 (after granting 4), `r_la_i`=6'b100001 → id 5, then id 0.
- Lock (`LA_PACKET_LOCK_EN`): buffer 3 sends head (tail 0), buffer 1 also requests → ids 3,3,3 until `tail_i[3]`=1 is granted; then `locked_o`=0 and id 1 next cycle. A bubble on `r_la_i[3]` mid-packet → no grant and `locked_o` stays 1.
- Reset asserted while LOCKED on owner 4 → `g_la_o`=0 during reset; after release, `locked_o`=0 and `r_la_i`=6'b010001 grants id 0.
